// File: rtl/wb_retire_stage.sv
// rtl/wb_retire_stage.sv - write-back/retire stage with configurable CSR read latency
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_retire_stage #(
    parameter int XLEN       = 32,
    parameter int RF_AW      = 5,
    parameter int CSR_RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_wb_valid,
    output logic             wb_allowin,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_gr_we,
    input  logic [RF_AW-1:0] in_dest,
    input  logic [XLEN-1:0]  in_result,
    input  logic             in_csr_re,
    input  logic             in_csr_we,
    input  logic [13:0]      in_csr_num,
    input  logic [XLEN-1:0]  in_csr_wmask,
    input  logic [XLEN-1:0]  in_csr_wvalue,
    input  logic             in_ertn,
    input  logic             in_ex,
    input  logic [5:0]       in_ecode,
    input  logic [8:0]       in_esubcode,
    input  logic [XLEN-1:0]  in_badv,
    output logic [13:0]      csr_num,
    output logic             csr_re,
    input  logic [XLEN-1:0]  csr_rvalue,
    output logic             csr_we,
    output logic [XLEN-1:0]  csr_wmask,
    output logic [XLEN-1:0]  csr_wvalue,
    output logic             wb_ex,
    output logic             ertn_flush,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [XLEN-1:0]  wb_csr_pc,
    output logic [XLEN-1:0]  wb_badv,
    output logic             fwd_valid,
    output logic             fwd_ready,
    output logic [RF_AW-1:0] fwd_dest,
    output logic [XLEN-1:0]  fwd_data,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [63:0]      retire_cnt,
    output logic [XLEN-1:0]  debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [RF_AW-1:0] debug_wb_rf_wnum,
    output logic [XLEN-1:0]  debug_wb_rf_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(CSR_RD_LAT);

    state_t           state, state_nxt;
    logic [1:0]       lat_cnt, lat_cnt_nxt;
    logic             wb_valid;

    logic [XLEN-1:0]  pc;
    logic             gr_we;
    logic [RF_AW-1:0] dest;
    logic [XLEN-1:0]  result;
    logic             csr_rd;
    logic             csr_wr;
    logic [13:0]      csr_addr;
    logic [XLEN-1:0]  csr_mask;
    logic [XLEN-1:0]  csr_data;
    logic             ertn;
    logic             ex;
    logic [5:0]       ecode;
    logic [8:0]       esubcode;
    logic [XLEN-1:0]  badv;

    logic             is_csr;
    logic             ready_go;
    logic             flush;
    logic             accept;
    logic             wait_start;
    logic [XLEN-1:0]  wdata;

    assign is_csr     = csr_rd | csr_wr;
    assign ready_go   = ~is_csr | ex | (CSR_RD_LAT == 0) | (state == S_DONE);
    assign wb_allowin = ~wb_valid | ready_go;
    assign flush      = wb_ex | ertn_flush;
    assign accept     = mem_wb_valid & wb_allowin & ~flush;
    // The wait starts as the CSR instruction is accepted, so MEM sees exactly CSR_RD_LAT stall cycles.
    assign wait_start = accept & (in_csr_re | in_csr_we) & ~in_ex & (CSR_RD_LAT != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid <= mem_wb_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wb_valid & wb_allowin) begin
            pc       <= in_pc;
            gr_we    <= in_gr_we;
            dest     <= in_dest;
            result   <= in_result;
            csr_rd   <= in_csr_re;
            csr_wr   <= in_csr_we;
            csr_addr <= in_csr_num;
            csr_mask <= in_csr_wmask;
            csr_data <= in_csr_wvalue;
            ertn     <= in_ertn;
            ex       <= in_ex;
            ecode    <= in_ecode;
            esubcode <= in_esubcode;
            badv     <= in_badv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        case (state)
            S_IDLE: begin
                if (wait_start) begin
                    state_nxt   = S_WAIT;
                    lat_cnt_nxt = 2'd1;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT) begin
                    state_nxt   = S_DONE;
                    lat_cnt_nxt = 2'd0;
                end else begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end
            end
            S_DONE: begin
                if (wait_start) begin
                    state_nxt   = S_WAIT;
                    lat_cnt_nxt = 2'd1;
                end else begin
                    state_nxt   = S_IDLE;
                    lat_cnt_nxt = 2'd0;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                lat_cnt_nxt = 2'd0;
            end
        endcase
    end

    assign wdata = is_csr ? csr_rvalue : result;

    assign csr_num    = csr_addr;
    assign csr_wmask  = csr_mask;
    assign csr_wvalue = csr_data;
    assign csr_re     = wb_valid & is_csr & ~ex;
    assign csr_we     = wb_valid & ready_go & csr_wr & ~ex;

    assign rf_we    = wb_valid & ready_go & gr_we & ~ex;
    assign rf_waddr = dest;
    assign rf_wdata = wdata;

    assign fwd_valid = wb_valid & gr_we & ~ex;
    assign fwd_ready = ready_go;
    assign fwd_dest  = dest;
    assign fwd_data  = wdata;

    assign wb_ex       = wb_valid & ex;
    assign ertn_flush  = wb_valid & ertn & ~ex;
    assign wb_ecode    = ex ? ecode : 6'd0;
    assign wb_esubcode = ex ? esubcode : 9'd0;
    assign wb_badv     = ex ? badv : '0;
    assign wb_csr_pc   = pc;

    assign debug_wb_pc       = pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = wdata;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= 64'd0;
        end else if (wb_valid & ready_go & ~ex) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// tb/tb_wb_retire_stage.sv - directed self-checking bench for wb_retire_stage
module tb_wb_retire_stage;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_wb_valid;
    logic             wb_allowin;
    logic [XLEN-1:0]  in_pc;
    logic             in_gr_we;
    logic [RF_AW-1:0] in_dest;
    logic [XLEN-1:0]  in_result;
    logic             in_csr_re;
    logic             in_csr_we;
    logic [13:0]      in_csr_num;
    logic [XLEN-1:0]  in_csr_wmask;
    logic [XLEN-1:0]  in_csr_wvalue;
    logic             in_ertn;
    logic             in_ex;
    logic [5:0]       in_ecode;
    logic [8:0]       in_esubcode;
    logic [XLEN-1:0]  in_badv;
    logic [13:0]      csr_num;
    logic             csr_re;
    logic [XLEN-1:0]  csr_rvalue;
    logic             csr_we;
    logic [XLEN-1:0]  csr_wmask;
    logic [XLEN-1:0]  csr_wvalue;
    logic             wb_ex;
    logic             ertn_flush;
    logic [5:0]       wb_ecode;
    logic [8:0]       wb_esubcode;
    logic [XLEN-1:0]  wb_csr_pc;
    logic [XLEN-1:0]  wb_badv;
    logic             fwd_valid;
    logic             fwd_ready;
    logic [RF_AW-1:0] fwd_dest;
    logic [XLEN-1:0]  fwd_data;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic [63:0]      retire_cnt;
    logic [XLEN-1:0]  debug_wb_pc;
    logic [3:0]       debug_wb_rf_we;
    logic [RF_AW-1:0] debug_wb_rf_wnum;
    logic [XLEN-1:0]  debug_wb_rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_retire_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .CSR_RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mem_wb_valid(mem_wb_valid), .wb_allowin(wb_allowin),
        .in_pc(in_pc), .in_gr_we(in_gr_we), .in_dest(in_dest), .in_result(in_result),
        .in_csr_re(in_csr_re), .in_csr_we(in_csr_we), .in_csr_num(in_csr_num),
        .in_csr_wmask(in_csr_wmask), .in_csr_wvalue(in_csr_wvalue), .in_ertn(in_ertn),
        .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_badv(in_badv),
        .csr_num(csr_num), .csr_re(csr_re), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_csr_pc(wb_csr_pc), .wb_badv(wb_badv),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef WB_RETIRE_CNT_EN
        return 64'(n);
`else
        return 64'(n) & 64'd0;
`endif
    endfunction

    task automatic idle_in();
        mem_wb_valid  = 1'b0;
        in_pc         = '0;
        in_gr_we      = 1'b0;
        in_dest       = '0;
        in_result     = '0;
        in_csr_re     = 1'b0;
        in_csr_we     = 1'b0;
        in_csr_num    = '0;
        in_csr_wmask  = '0;
        in_csr_wvalue = '0;
        in_ertn       = 1'b0;
        in_ex         = 1'b0;
        in_ecode      = '0;
        in_esubcode   = '0;
        in_badv       = '0;
    endtask

    task automatic alu_in(input logic [XLEN-1:0] pc, input logic [RF_AW-1:0] d, input logic [XLEN-1:0] r);
        idle_in();
        mem_wb_valid = 1'b1;
        in_pc        = pc;
        in_gr_we     = 1'b1;
        in_dest      = d;
        in_result    = r;
    endtask

    task automatic csr_in(input logic [XLEN-1:0] pc, input logic [RF_AW-1:0] d);
        idle_in();
        mem_wb_valid  = 1'b1;
        in_pc         = pc;
        in_gr_we      = 1'b1;
        in_dest       = d;
        in_result     = 32'hDEAD;
        in_csr_re     = 1'b1;
        in_csr_we     = 1'b1;
        in_csr_num    = 14'h0;
        in_csr_wmask  = 32'hFFFF_FFFF;
        in_csr_wvalue = 32'h5A;
    endtask

    // Drive just after the falling edge, sample 1 ns later, well clear of the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        csr_rvalue = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        next_cycle();
        reset = 1'b0;
        #1;
        check("rst_allowin", 64'(wb_allowin), 64'd1);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_csr_re", 64'(csr_re), 64'd0);
        check("rst_csr_we", 64'(csr_we), 64'd0);
        check("rst_wb_ex", 64'(wb_ex), 64'd0);
        check("rst_ertn", 64'(ertn_flush), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_retire_cnt", retire_cnt, 64'd0);

        // back-to-back ALU ops
        next_cycle();
        alu_in(32'h1c00_0000, 5'd5, 32'h11);
        #1 check("alu_allowin0", 64'(wb_allowin), 64'd1);
        next_cycle();
        alu_in(32'h1c00_0004, 5'd6, 32'h22);
        #1;
        check("alu1_rf_we", 64'(rf_we), 64'd1);
        check("alu1_waddr", 64'(rf_waddr), 64'd5);
        check("alu1_wdata", 64'(rf_wdata), 64'h11);
        check("alu1_dbg_we", 64'(debug_wb_rf_we), 64'hF);
        check("alu1_fwd", 64'({fwd_valid, fwd_ready}), 64'd3);
        check("alu1_allowin", 64'(wb_allowin), 64'd1);
        next_cycle();
        idle_in();
        #1;
        check("alu2_rf_we", 64'(rf_we), 64'd1);
        check("alu2_waddr", 64'(debug_wb_rf_wnum), 64'd6);
        check("alu2_wdata", 64'(debug_wb_rf_wdata), 64'h22);
        check("alu2_pc", 64'(debug_wb_pc), 64'h1c00_0004);
        check("alu2_allowin", 64'(wb_allowin), 64'd1);

        // csrxchg with two-cycle read latency, a following ALU op waits in MEM
        next_cycle();
        check("alu_cnt", retire_cnt, exp_cnt(2));
        check("alu_drain_rf_we", 64'(rf_we), 64'd0);
        csr_in(32'h1c00_0008, 5'd4);
        #1 check("csr_accept_allowin", 64'(wb_allowin), 64'd1);
        next_cycle();
        alu_in(32'h1c00_000c, 5'd7, 32'h77);
        csr_rvalue = 32'hA5;
        #1;
        check("csr_w1_allowin", 64'(wb_allowin), 64'd0);
        check("csr_w1_fwd_ready", 64'(fwd_ready), 64'd0);
        check("csr_w1_fwd_valid", 64'(fwd_valid), 64'd1);
        check("csr_w1_csr_re", 64'(csr_re), 64'd1);
        check("csr_w1_csr_we", 64'(csr_we), 64'd0);
        check("csr_w1_rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        #1;
        check("csr_w2_allowin", 64'(wb_allowin), 64'd0);
        check("csr_w2_fwd_ready", 64'(fwd_ready), 64'd0);
        check("csr_w2_csr_we", 64'(csr_we), 64'd0);
        next_cycle();
        #1;
        check("csr_ret_csr_we", 64'(csr_we), 64'd1);
        check("csr_ret_wvalue", 64'(csr_wvalue), 64'h5A);
        check("csr_ret_csr_num", 64'(csr_num), 64'h0);
        check("csr_ret_rf_we", 64'(rf_we), 64'd1);
        check("csr_ret_waddr", 64'(rf_waddr), 64'd4);
        check("csr_ret_wdata", 64'(rf_wdata), 64'hA5);
        check("csr_ret_allowin", 64'(wb_allowin), 64'd1);
        next_cycle();
        idle_in();
        #1;
        check("post_csr_csr_we", 64'(csr_we), 64'd0);
        check("post_csr_rf_we", 64'(rf_we), 64'd1);
        check("post_csr_wdata", 64'(rf_wdata), 64'h77);
        check("post_csr_waddr", 64'(rf_waddr), 64'd7);

        // exception with a valid follower in MEM
        next_cycle();
        alu_in(32'h1c00_0100, 5'd9, 32'h99);
        in_ex       = 1'b1;
        in_ecode    = 6'h0B;
        in_esubcode = 9'h1;
        in_badv     = 32'h1234;
        next_cycle();
        alu_in(32'h1c00_0104, 5'd10, 32'hAA);
        #1;
        check("ex_wb_ex", 64'(wb_ex), 64'd1);
        check("ex_ecode", 64'(wb_ecode), 64'h0B);
        check("ex_esubcode", 64'(wb_esubcode), 64'h1);
        check("ex_pc", 64'(wb_csr_pc), 64'h1c00_0100);
        check("ex_badv", 64'(wb_badv), 64'h1234);
        check("ex_rf_we", 64'(rf_we), 64'd0);
        check("ex_csr_we", 64'(csr_we), 64'd0);
        check("ex_fwd_valid", 64'(fwd_valid), 64'd0);

        // ertn arrives right after the flush, then a follower in MEM
        next_cycle();
        idle_in();
        mem_wb_valid = 1'b1;
        in_pc        = 32'h1c00_0200;
        in_ertn      = 1'b1;
        #1;
        check("ex_next_wb_ex", 64'(wb_ex), 64'd0);
        check("ex_next_rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        alu_in(32'h1c00_0204, 5'd11, 32'hBB);
        #1;
        check("ertn_flush", 64'(ertn_flush), 64'd1);
        check("ertn_wb_ex", 64'(wb_ex), 64'd0);
        check("ertn_rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        idle_in();
        #1;
        check("ertn_next_flush", 64'(ertn_flush), 64'd0);
        check("ertn_next_rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        #1 check("ertn_drain_rf_we", 64'(rf_we), 64'd0);

        // reset while waiting on the CSR read
        csr_in(32'h1c00_0300, 5'd3);
        next_cycle();
        idle_in();
        #1;
        check("rw_wait_allowin", 64'(wb_allowin), 64'd0);
        check("rw_wait_csr_re", 64'(csr_re), 64'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check("rw_allowin", 64'(wb_allowin), 64'd1);
        check("rw_strobes", 64'({csr_re, csr_we, rf_we, fwd_valid, wb_ex, ertn_flush}), 64'd0);
        check("rw_retire_cnt", retire_cnt, 64'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1 check("rw_no_csr_we", 64'(csr_we | rf_we), 64'd0);
        end

        // ten retires plus one exception
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            alu_in(32'h1c00_0400 + 32'(i * 4), 5'(i + 1), 32'(i));
        end
        next_cycle();
        alu_in(32'h1c00_0500, 5'd12, 32'h0);
        in_ex = 1'b1;
        next_cycle();
        idle_in();
        repeat (2) next_cycle();
        #1 check("cnt_final", retire_cnt, exp_cnt(10));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
